serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised multi-cycle adder: adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock.
- Carry is registered between chunks.
- Valid/ready handshake on both input and output.
- Next-generation arithmetic block in the circuitry task set: generalises the 1-bit full-adder cell to an N-bit sequential datapath built from a CHUNK-bit adder slice.

Parameters:
WIDTH, 8, operand and sum width in bits; must be >= 1
CHUNK, 1, bits added per clock; must be >= 1 and divide WIDTH exactly, else elaboration error
(derived) STEPS = WIDTH/CHUNK, number of RUN cycles per operation

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands/cin valid
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result, mod 2^WIDTH
cout  output  1  carry-out of the MSB
busy  output  1  operation in progress (state RUN)

Behaviour:
- Reset (async assert, takes effect immediately): state=IDLE, out_valid=0, sum=0, cout=0, busy=0, chunk counter=0, carry reg=0. in_ready=1 during and after reset (decoded from IDLE).
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready at an edge: capture a, b, cin into internal regs; counter=0; go to RUN.
  - RUN: busy=1, in_ready=0. Each edge adds chunk[counter] of a and b plus the carry reg via the slice. Writes the CHUNK sum bits into result bits [counter*CHUNK +: CHUNK]. Carry reg takes the slice carry-out; counter increments. After edge STEPS, go to DONE.
  - DONE: out_valid=1, sum/cout hold the final result and stay stable. On out_ready high at an edge, go to IDLE and drop out_valid.
- Latency: acceptance at edge T gives out_valid=1 in the cycle after edge T+STEPS.
- Minimum issue interval is STEPS+2 cycles; there is no accept in DONE (no bypass IDLE->accept in the same cycle as the pop).
- Arithmetic: {cout,sum} = a + b + cin, exact to WIDTH+1 bits; cin enters chunk 0 only.
- Input phase:
  - in_valid in RUN/DONE is ignored: no capture, no error.
  - Operand changes after acceptance have no effect.
- Output phase:
  - out_ready while not DONE has no effect.
  - out_valid stays high indefinitely under back-pressure.
- sum/cout are don't-care while out_valid=0; they are internal regs driven directly (no combinational path from inputs to outputs).
- in_ready and busy are decoded from the state register only.
- Reset mid-RUN or mid-DONE aborts the operation and discards the result; the first post-reset accept behaves as from power-up.
- WIDTH=CHUNK (STEPS=1): one RUN cycle, otherwise identical.

Optional Feature:
- Macro SERIAL_ADDER_SUBTRACT_EN.
- Defined:
  - Extra input port sub (1 bit), captured with the operands.
  - sub=1: sum = a - b - cin mod 2^WIDTH, implemented as a + ~b + !cin; cout=1 means no borrow (a >= b+cin).
  - sub=0: plain add.
- Undefined: no sub port; add only; logic identical to the add path.

Decomposition:
- Package serial_adder_pkg:
  - state enum (IDLE, RUN, DONE), 2-bit encoding.
  - function computing STEPS and the counter width ($clog2(STEPS) with minimum 1).
- Sub-module chunk_adder: combinational CHUNK-bit ripple adder (a, b, cin -> s, cout), built from per-bit full-adder equations. Instantiated once in serial_adder.

Test Plan:
- WIDTH=8,CHUNK=1: a=0xFF,b=0x01,cin=0 -> out_valid exactly 8 cycles after accept, sum=0x00, cout=1.
- WIDTH=8,CHUNK=4: a=0x3C,b=0x45,cin=1 -> out_valid 2 cycles after accept, sum=0x82, cout=0; then random sweep (1000 ops) vs a+b+cin reference.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, sum/cout stable, in_ready=0. Pulse in_valid with new operands meanwhile -> ignored; pop returns the original result.
- Reset mid-RUN: assert rst at counter=3 (CHUNK=1) -> immediately out_valid=0, busy=0, in_ready=1. Next op a=0x10,b=0x20,cin=0 -> sum=0x30, cout=0.
- Boundary WIDTH=CHUNK=8: a=0x80,b=0x80,cin=1 -> 1-cycle latency, sum=0x01, cout=1.
- SERIAL_ADDER_SUBTRACT_EN defined, WIDTH=8, sub=1:
  - a=0x05,b=0x07,cin=0 -> sum=0xFE, cout=0.
  - a=0x07,b=0x05,cin=0 -> sum=0x02, cout=1.
  - a=0x07,b=0x05,cin=1 -> sum=0x01, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// serial_adder_pkg : shared state encoding and sizing helpers for serial_adder
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of RUN cycles; guarded so a bad CHUNK fails in the top-level check
   function automatic int calc_steps(input int width, input int chunk);
      return (chunk > 0) ? (width / chunk) : 1;
   endfunction

   function automatic int calc_cnt_w(input int steps);
      return (steps <= 1) ? 1 : $clog2(steps);
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_chunk_adder.sv
// ============================================================================
// chunk_adder : combinational CHUNK-bit ripple adder from full-adder equations
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module chunk_adder #(
   parameter int CHUNK = 1
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   always_comb begin
      logic carry;
      s     = '0;
      carry = cin;
      for (int i = 0; i < CHUNK; i++) begin
         s[i]  = a[i] ^ b[i] ^ carry;
         carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : multi-cycle WIDTH-bit adder, CHUNK bits per clock, valid/ready
// Optional subtract mode enabled by macro SERIAL_ADDER_SUBTRACT_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUBTRACT_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int               STEPS      = calc_steps(WIDTH, CHUNK);
   localparam int               CNT_W      = calc_cnt_w(STEPS);
   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(STEPS - 1);
   localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

   if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 1 and a multiple of CHUNK >= 1");
   end

   state_t             state;
   state_t             next_state;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [WIDTH-1:0]   sum_r;
   logic               carry_r;
   logic               cout_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [31:0]        shamt;
   logic [CHUNK-1:0]   a_chunk;
   logic [CHUNK-1:0]   b_chunk;
   logic [CHUNK-1:0]   s_chunk;
   logic               c_out;
   logic               last;
   logic [WIDTH-1:0]   b_cap;
   logic               c_cap;

   // Subtraction is a + ~b + !cin, folded into the captured operands
`ifdef SERIAL_ADDER_SUBTRACT_EN
   assign b_cap = sub ? ~b : b;
   assign c_cap = cin ^ sub;
`else
   assign b_cap = b;
   assign c_cap = cin;
`endif

   always_comb begin
      shamt   = 32'(cnt_r) * 32'(CHUNK);
      a_chunk = CHUNK'(a_r >> shamt);
      b_chunk = CHUNK'(b_r >> shamt);
   end

   assign last = (cnt_r == LAST_CNT);

   chunk_adder #(
      .CHUNK (CHUNK)
   ) u_chunk_adder (
      .a    (a_chunk),
      .b    (b_chunk),
      .cin  (carry_r),
      .s    (s_chunk),
      .cout (c_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (in_valid)  next_state = RUN;
         RUN:     if (last)      next_state = DONE;
         DONE:    if (out_ready) next_state = IDLE;
         default:                next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r     <= '0;
         b_r     <= '0;
         sum_r   <= '0;
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         cnt_r   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r     <= a;
                  b_r     <= b_cap;
                  carry_r <= c_cap;
                  cnt_r   <= '0;
               end
            end
            RUN: begin
               sum_r   <= (sum_r & ~(CHUNK_MASK << shamt)) | (WIDTH'(s_chunk) << shamt);
               carry_r <= c_out;
               cnt_r   <= cnt_r + CNT_W'(1);
               if (last) cout_r <= c_out;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state == RUN);
   assign out_valid = (state == DONE);
   assign sum       = sum_r;
   assign cout      = cout_r;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder : scoreboard bench over three serial_adder configurations
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

   localparam int W = 8;
   localparam int N = 3;   // instance 0: CHUNK=1, 1: CHUNK=4, 2: CHUNK=8

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         in_valid  [N];
   logic         in_ready  [N];
   logic         cin       [N];
   logic         sub       [N];
   logic         out_valid [N];
   logic         out_ready [N];
   logic         cout      [N];
   logic         busy      [N];
   logic [W-1:0] a         [N];
   logic [W-1:0] b         [N];
   logic [W-1:0] sum       [N];

   logic [W:0]   exp_q [N][$];

   int checks = 0;
   int errors = 0;

   for (genvar i = 0; i < N; i++) begin : g_dut
      serial_adder #(
         .WIDTH (W),
         .CHUNK ((i == 0) ? 1 : (i == 1) ? 4 : 8)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[i]),
         .in_ready  (in_ready[i]),
         .a         (a[i]),
         .b         (b[i]),
         .cin       (cin[i]),
`ifdef SERIAL_ADDER_SUBTRACT_EN
         .sub       (sub[i]),
`endif
         .out_valid (out_valid[i]),
         .out_ready (out_ready[i]),
         .sum       (sum[i]),
         .cout      (cout[i]),
         .busy      (busy[i])
      );

      // Monitor: a result is consumed on any cycle with out_valid & out_ready
      always @(negedge clk) begin
         logic [W:0] e;
         if (!rst && out_valid[i] && out_ready[i]) begin
            checks++;
            if (exp_q[i].size() == 0) begin
               errors++;
               $display("FAIL unexpected_result dut%0d: got cout=%b sum=%h, required no output",
                        i, cout[i], sum[i]);
            end else begin
               e = exp_q[i].pop_front();
               if ({cout[i], sum[i]} !== e) begin
                  errors++;
                  $display("FAIL result dut%0d: got cout=%b sum=%h, required cout=%b sum=%h",
                           i, cout[i], sum[i], e[W], e[W-1:0]);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic int steps_of(input int idx);
      return (idx == 0) ? 8 : (idx == 1) ? 2 : 1;
   endfunction

   // Returns at the first negedge where the result is presented
   task automatic run_op(input int idx, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input logic sv, input logic [W-1:0] exp_sum,
                         input logic exp_cout, input bit chk_lat);
      int n;
      @(posedge clk); #1;
      n = 0;
      while (!in_ready[idx] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready[idx]) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout dut%0d: got in_ready=0, required 1", idx);
         return;
      end
      a[idx]        = av;
      b[idx]        = bv;
      cin[idx]      = cv;
      sub[idx]      = sv;
      in_valid[idx] = 1'b1;
      exp_q[idx].push_back({exp_cout, exp_sum});
      @(posedge clk); #1;
      in_valid[idx] = 1'b0;
      if (chk_lat) begin
         for (int k = 0; k <= steps_of(idx); k++) begin
            @(negedge clk);
            chk($sformatf("latency dut%0d k=%0d out_valid", idx, k),
                32'(out_valid[idx]), 32'(k == steps_of(idx)));
            if (k < steps_of(idx)) @(posedge clk);
         end
      end else begin
         n = 0;
         @(negedge clk);
         while (!out_valid[idx] && n < 60) begin
            @(negedge clk);
            n++;
         end
         if (!out_valid[idx]) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout dut%0d: got out_valid=0, required 1", idx);
         end
      end
   endtask

   initial begin
      logic [W:0]   r;
      logic [W-1:0] av, bv;
      logic         cv;

      for (int i = 0; i < N; i++) begin
         in_valid[i]  = 1'b0;
         a[i]         = '0;
         b[i]         = '0;
         cin[i]       = 1'b0;
         sub[i]       = 1'b0;
         out_ready[i] = 1'b1;
      end
      rst = 1'b1;
      #3;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("reset dut%0d in_ready", i),  32'(in_ready[i]),  32'd1);
         chk($sformatf("reset dut%0d out_valid", i), 32'(out_valid[i]), 32'd0);
         chk($sformatf("reset dut%0d busy", i),      32'(busy[i]),      32'd0);
         chk($sformatf("reset dut%0d sum", i),       32'(sum[i]),       32'd0);
         chk($sformatf("reset dut%0d cout", i),      32'(cout[i]),      32'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors with latency checks
      run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      run_op(1, 8'h3C, 8'h45, 1'b1, 1'b0, 8'h82, 1'b0, 1'b1);
      run_op(2, 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
      run_op(0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1);
      run_op(2, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);

      // Back-pressure: result held, new request ignored
      out_ready[0] = 1'b0;
      run_op(0, 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         in_valid[0] = (c == 1);
         if (c == 1) begin
            a[0] = 8'hFF;
            b[0] = 8'hFF;
         end
         @(negedge clk);
         chk($sformatf("hold c=%0d out_valid", c), 32'(out_valid[0]), 32'd1);
         chk($sformatf("hold c=%0d sum", c),       32'(sum[0]),       32'h47);
         chk($sformatf("hold c=%0d cout", c),      32'(cout[0]),      32'd0);
         chk($sformatf("hold c=%0d in_ready", c),  32'(in_ready[0]),  32'd0);
      end
      @(posedge clk); #1;
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      chk("after_pop in_ready", 32'(in_ready[0]), 32'd1);
      chk("after_pop busy",     32'(busy[0]),     32'd0);

      // Reset in the middle of RUN at counter=3
      a[0] = 8'h11;
      b[0] = 8'h22;
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      chk("pre_reset busy", 32'(busy[0]), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_reset out_valid", 32'(out_valid[0]), 32'd0);
      chk("mid_reset busy",      32'(busy[0]),      32'd0);
      chk("mid_reset in_ready",  32'(in_ready[0]),  32'd1);
      @(negedge clk);
      rst = 1'b0;
      run_op(0, 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b1);

`ifdef SERIAL_ADDER_SUBTRACT_EN
      run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
      run_op(0, 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
      run_op(0, 8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
      run_op(1, 8'h05, 8'h05, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b0);
`endif

      // Random sweep on the CHUNK=4 instance
      for (int k = 0; k < 1000; k++) begin
         av = W'($urandom_range(0, 255));
         bv = W'($urandom_range(0, 255));
         cv = 1'($urandom_range(0, 1));
         r  = {1'b0, av} + {1'b0, bv} + (W + 1)'(cv);
         run_op(1, av, bv, cv, 1'b0, r[W-1:0], r[W], 1'b0);
      end

      repeat (4) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("drained dut%0d queue", i), 32'(exp_q[i].size()), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
